ace_snapshot_encoder: RTL
=========================

# ace_snapshot_encoder

Streams a RAM snapshot of the Jupiter Ace (0x2000–0xFFFF) out as a `.ACE`-format byte stream: the encode side of the `.ACE` loader's run-length scheme. It sits between the Ace RAM read port and the HPS upload path. Decoding its output with the loader must restore memory byte-exact. It reads memory sequentially, run-length encodes it with escape byte 0xED, and terminates the stream with `ED 00`.

## Interface
Parameters:
- START_ADDR, 16'h2000, first address read
- END_ADDR, 16'hFFFF, last address read (inclusive; END_ADDR ≥ START_ADDR)
- MIN_RUN, 3, shortest run emitted as an escape triple (range 2–4)

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a snapshot; ignored while busy
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the terminator byte is accepted
- mem_addr  out  16  RAM read address
- mem_rd  out  1  read strobe; mem_data is valid exactly 1 cycle later
- mem_data  in  8  RAM read data
- out_data  out  8  encoded byte
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts the byte when out_valid && out_ready

## Operation
- Escape byte ESC = 0xED. Encoded forms:
  - literal byte `b`
  - triple `ED n b`, meaning n copies of b, with 1 ≤ n ≤ 255
  - terminator `ED 00`
- The block tracks one run: run_byte and run_len (8-bit, 1..255).
- Each fetched byte is either appended to the current run or closes it:
  - Append when it equals run_byte and run_len < 255.
  - Otherwise flush the current run, then start a new run with the byte and length 1.
- Flush rule:
  - If run_len ≥ MIN_RUN, or run_byte == ESC, emit the triple `ED run_len run_byte`.
  - Otherwise emit run_byte literally run_len times.
  - A lone 0xED therefore always goes out as `ED 01 ED`.
- After END_ADDR is processed, flush the last run, emit `ED 00`, then pulse done.
- States:
  - IDLE
  - FETCH: mem_rd high for 1 cycle
  - WAIT: data lands
  - SCAN: compare / append
  - FLUSH_ESC
  - FLUSH_CNT
  - FLUSH_BYTE
  - FLUSH_LIT: loops run_len times
  - TERM_ESC
  - TERM_ZERO
  - DONE
- Transitions:
  - IDLE → FETCH on start.
  - SCAN → FETCH when appending and not at end.
  - SCAN → flush states otherwise; flush returns to SCAN to seed the new run, or goes to TERM_ESC when at end.
  - TERM_ZERO → DONE on acceptance.
  - DONE → IDLE.
- Address counter is 17 bits wide or carries a last flag. END_ADDR = 0xFFFF must never wrap to 0x0000 and re-read.

## Timing
- Reset values:
  - busy = 0, done = 0, mem_rd = 0, out_valid = 0
  - mem_addr = START_ADDR, out_data = 0x00
  - state IDLE
- start → mem_rd for START_ADDR: 1 cycle.
- mem_rd → data sampled: 1 cycle.
- One RAM read at most every 3 cycles; reads stall while any output byte is pending.
- Handshake rules:
  - While out_valid && !out_ready, out_data holds stable and no mem_rd is issued.
  - The next byte may be presented in the cycle after acceptance.
- start while busy: ignored. start in the same cycle as done: ignored.
- reset_n low at any point: next edge returns to reset values. A partial stream is abandoned and no terminator is emitted.

## Configuration
- ACE_RLE_EN defined: full run-length encoding as above.
- ACE_RLE_EN undefined:
  - no run accumulation; every non-ESC byte is emitted literally
  - every 0xED is emitted as `ED 01 ED`
  - terminator unchanged
  - the output stays loader-compatible
- SCAN logic and run_len register are compiled out.

## Structure
- Shared package ace_pkg:
  - ACE_ESC = 8'hED
  - ACE_MAX_RUN = 8'd255
  - encoder state enum
- Sub-module ace_run_flush: takes run_byte/run_len/start and owns the FLUSH_* sequencing and out_* handshake. It returns flush_done. It is reused for the terminator with (ESC, len 0, terminator mode).

## Test plan
- START=0x2000, END=0x2004, data `11 22 ED 33 33` → `11 22 ED 01 ED 33 33 ED 00`; done once; 5 mem_rd.
- Data `44 44 44` → `ED 03 44 ED 00`.
- Defaults, RAM all 0x00 (57344 bytes) → 224× `ED FF 00`, then `ED E0 00`, `ED 00`; 677 bytes total; no read of 0x0000 after 0xFFFF.
- Random RAM with random out_ready backpressure → stream identical to the zero-stall run; decoding with the `.ACE` loader model restores RAM byte-exact.
- reset_n low for 1 cycle during FLUSH_CNT → next cycle out_valid = 0, busy = 0, done never pulses; a new start yields the complete correct stream.
- ACE_RLE_EN undefined, data `44 44 44 ED` → `44 44 44 ED 01 ED ED 00`.

Source files
------------

// File: rtl/ace_pkg.sv
// Shared constants and the state encoding used by the .ACE snapshot encoder and its flush unit.
package ace_pkg;

   localparam logic [7:0] ACE_ESC     = 8'hED;
   localparam logic [7:0] ACE_MAX_RUN = 8'd255;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_SCAN,
      ST_FLUSH_ESC,
      ST_FLUSH_CNT,
      ST_FLUSH_BYTE,
      ST_FLUSH_LIT,
      ST_TERM_ESC,
      ST_TERM_ZERO,
      ST_DONE
   } enc_state_t;

endpackage

// File: rtl/ace_run_flush.sv
// Emits one run (escape triple or repeated literal) or the ED 00 terminator over a valid/ready port.
// Handshake: a byte transfers on any clk_sys edge where out_valid && out_ready; out_data is held until then.
module ace_run_flush
   import ace_pkg::*;
#(
   parameter int MIN_RUN = 3
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       flush_start,
   input  logic       term,
   input  logic [7:0] run_byte,
   input  logic [7:0] run_len,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       flush_done,
   output logic [3:0] flush_state
);

   enc_state_t state, state_nxt;
   logic [7:0] lit_cnt, lit_cnt_nxt;
   logic       use_triple;

   // An escape byte can never travel as a literal, whatever its run length.
   assign use_triple  = (run_len >= 8'(MIN_RUN)) || (run_byte == ACE_ESC);
   assign flush_state = state;

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         lit_cnt <= 8'd0;
      end else begin
         state   <= state_nxt;
         lit_cnt <= lit_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      lit_cnt_nxt = lit_cnt;
      out_data    = 8'h00;
      out_valid   = 1'b0;
      flush_done  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (flush_start) begin
               if (term)            state_nxt = ST_TERM_ESC;
               else if (use_triple) state_nxt = ST_FLUSH_ESC;
               else begin
                  state_nxt   = ST_FLUSH_LIT;
                  lit_cnt_nxt = run_len;
               end
            end
         end
         ST_FLUSH_ESC: begin
            out_valid = 1'b1;
            out_data  = ACE_ESC;
            if (out_ready) state_nxt = ST_FLUSH_CNT;
         end
         ST_FLUSH_CNT: begin
            out_valid = 1'b1;
            out_data  = run_len;
            if (out_ready) state_nxt = ST_FLUSH_BYTE;
         end
         ST_FLUSH_BYTE: begin
            out_valid = 1'b1;
            out_data  = run_byte;
            if (out_ready) begin
               state_nxt  = ST_IDLE;
               flush_done = 1'b1;
            end
         end
         ST_FLUSH_LIT: begin
            out_valid = 1'b1;
            out_data  = run_byte;
            if (out_ready) begin
               if (lit_cnt == 8'd1) begin
                  state_nxt  = ST_IDLE;
                  flush_done = 1'b1;
               end else begin
                  lit_cnt_nxt = lit_cnt - 8'd1;
               end
            end
         end
         ST_TERM_ESC: begin
            out_valid = 1'b1;
            out_data  = ACE_ESC;
            if (out_ready) state_nxt = ST_TERM_ZERO;
         end
         ST_TERM_ZERO: begin
            out_valid = 1'b1;
            out_data  = 8'h00;
            if (out_ready) begin
               state_nxt  = ST_IDLE;
               flush_done = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/ace_snapshot_encoder.sv
// Streams Ace RAM [START_ADDR..END_ADDR] as a .ACE byte stream terminated by ED 00.
// Build option ACE_RLE_EN: defined = run accumulation; undefined = every byte goes out on its own.
module ace_snapshot_encoder
   import ace_pkg::*;
#(
   parameter logic [15:0] START_ADDR = 16'h2000,
   parameter logic [15:0] END_ADDR   = 16'hFFFF,
   parameter int          MIN_RUN    = 3
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_data,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  dbg_state
);

   enc_state_t state, state_nxt;
   logic       last_q;       // END_ADDR has been read; mem_addr never steps past it
   logic [7:0] run_byte;
   logic [7:0] run_len_w;
   logic       flush_start;
   logic       flush_done;
   logic [3:0] flush_state;

`ifdef ACE_RLE_EN
   logic [7:0] data_q;
   logic [7:0] run_len;
   logic       run_valid;
   logic       final_q;      // the flush in progress carries the last byte of memory
   logic       run_match;

   assign run_match = (data_q == run_byte) && (run_len != ACE_MAX_RUN);
   assign run_len_w = run_len;
`else
   assign run_len_w = 8'd1;
`endif

   assign mem_rd      = (state == ST_FETCH);
   assign busy        = (state != ST_IDLE) && (state != ST_DONE);
   assign done        = (state == ST_DONE);
   assign flush_start = (state == ST_FLUSH_ESC) || (state == ST_TERM_ESC);
   assign dbg_state   = (flush_state != ST_IDLE) ? flush_state : state;

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         mem_addr  <= START_ADDR;
         last_q    <= 1'b0;
         run_byte  <= 8'h00;
`ifdef ACE_RLE_EN
         data_q    <= 8'h00;
         run_len   <= 8'd0;
         run_valid <= 1'b0;
         final_q   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mem_addr  <= START_ADDR;
                  last_q    <= 1'b0;
`ifdef ACE_RLE_EN
                  run_valid <= 1'b0;
                  final_q   <= 1'b0;
`endif
               end
            end
            ST_FETCH: begin
               if (mem_addr == END_ADDR) last_q <= 1'b1;
               else                      mem_addr <= mem_addr + 16'd1;
            end
`ifdef ACE_RLE_EN
            ST_WAIT: data_q <= mem_data;
            ST_SCAN: begin
               if (!run_valid) begin
                  run_byte  <= data_q;
                  run_len   <= 8'd1;
                  run_valid <= 1'b1;
                  final_q   <= last_q;
               end else if (run_match) begin
                  run_len <= run_len + 8'd1;
                  final_q <= last_q;
               end
            end
            ST_FLUSH_ESC: if (flush_done) run_valid <= 1'b0;
`else
            ST_WAIT: run_byte <= mem_data;
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (start) state_nxt = ST_FETCH;
         ST_FETCH: state_nxt = ST_WAIT;
`ifdef ACE_RLE_EN
         ST_WAIT:  state_nxt = ST_SCAN;
         // A mismatch flushes the old run and comes back here to seed with the held byte.
         ST_SCAN: begin
            if (run_valid && !run_match) state_nxt = ST_FLUSH_ESC;
            else if (last_q)             state_nxt = ST_FLUSH_ESC;
            else                         state_nxt = ST_FETCH;
         end
         ST_FLUSH_ESC: if (flush_done) state_nxt = final_q ? ST_TERM_ESC : ST_SCAN;
`else
         ST_WAIT:  state_nxt = ST_FLUSH_ESC;
         ST_FLUSH_ESC: if (flush_done) state_nxt = last_q ? ST_TERM_ESC : ST_FETCH;
`endif
         ST_TERM_ESC: if (flush_done) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   ace_run_flush #(
      .MIN_RUN (MIN_RUN)
   ) u_flush (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .flush_start (flush_start),
      .term        (state == ST_TERM_ESC),
      .run_byte    (run_byte),
      .run_len     (run_len_w),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .flush_done  (flush_done),
      .flush_state (flush_state)
   );

endmodule
